// File: rtl/shift_deserializer_if.sv
// Serial-in / word-out bundle for shift_deserializer.
// parity_err exists only when PARITY_EN is defined.
interface shift_deserializer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             ser_in;
    logic             ser_valid;
    logic             dir;
    logic             flush;
    logic             out_ready;
    logic             ovr_clr;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;
`ifdef PARITY_EN
    logic             parity_err;
`endif

    modport master (
`ifdef PARITY_EN
        input  parity_err,
`endif
        output ser_in,
        output ser_valid,
        output dir,
        output flush,
        output out_ready,
        output ovr_clr,
        input  out_data,
        input  out_valid,
        input  busy,
        input  bit_cnt,
        input  overrun
    );

    modport slave (
`ifdef PARITY_EN
        output parity_err,
`endif
        input  ser_in,
        input  ser_valid,
        input  dir,
        input  flush,
        input  out_ready,
        input  ovr_clr,
        output out_data,
        output out_valid,
        output busy,
        output bit_cnt,
        output overrun
    );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver with a one-word output holding register.
// Define PARITY_EN to expect a trailing even-parity bit per word.
module shift_deserializer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_deserializer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        RECV
`ifdef PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d, sh_next;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;
    logic             done;
    logic             dir_eff;
    logic [WIDTH-1:0] word;
`ifdef PARITY_EN
    logic             perr_q, perr_d;
    logic             perr_new;
`endif

    // Direction is latched on a word's first bit; later bits reuse it.
    assign dir_eff = (state_q == IDLE) ? bus.dir : dir_q;
    assign sh_next = dir_eff ? {sh_q[WIDTH-2:0], bus.ser_in}
                             : {bus.ser_in, sh_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        dir_d   = dir_q;
        done    = 1'b0;
        word    = sh_next;
`ifdef PARITY_EN
        perr_new = 1'b0;
`endif
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (bus.ser_valid) begin
            unique case (state_q)
                IDLE: begin
                    dir_d   = bus.dir;
                    sh_d    = sh_next;
                    cnt_d   = CNT_W'(1);
                    state_d = RECV;
                end
                RECV: begin
                    sh_d = sh_next;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_EN
                        state_d = PARITY;
                        cnt_d   = CNT_W'(WIDTH);
`else
                        done    = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    done     = 1'b1;
                    word     = sh_q;
                    perr_new = (^sh_q) ^ bus.ser_in;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        ovr_d  = ovr_q;
`ifdef PARITY_EN
        perr_d = perr_q;
`endif
        if (bus.ovr_clr)
            ovr_d = 1'b0;
        if (done && vld_q && !bus.out_ready) begin
            ovr_d = 1'b1;
        end else if (done) begin
            data_d = word;
            vld_d  = 1'b1;
`ifdef PARITY_EN
            perr_d = perr_new;
`endif
        end else if (vld_q && bus.out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            dir_q   <= 1'b0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
`ifdef PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = vld_q;
    assign bus.bit_cnt   = cnt_q;
    assign bus.busy      = (cnt_q != '0);
    assign bus.overrun   = ovr_q;
`ifdef PARITY_EN
    assign bus.parity_err = perr_q;
`endif
endmodule
